// File: rtl/bpu_pkg.sv
// Shared types and constants for the branch predictor tables.
// Holds the table FSM states and the 2-bit counter names.
package bpu_pkg;

    typedef enum logic {
        INIT,
        RUN
    } pht_state_e;

    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    // Weakly not-taken start value for a counter of the given width.
    function automatic int init_ctr(input int ctr_w);
        return (1 << (ctr_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/bimodal_pht_sat_ctr_next.sv
// Saturating up/down step for one prediction counter.
// Shared by the training write path and the bypass path.
module sat_ctr_next #(
    parameter int CTR_W = 2
) (
    input  logic [CTR_W-1:0] ctr,
    input  logic             taken,
    output logic [CTR_W-1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != '1)
                ctr_next = ctr + CTR_W'(1);
        end else begin
            if (ctr != '0)
                ctr_next = ctr - CTR_W'(1);
        end
    end

endmodule

// File: rtl/bimodal_pht.sv
// Bimodal pattern history table with init sweep and 1-cycle lookup.
// Define BIMODAL_PHT_BYPASS_EN for write-first same-index forwarding.
module bimodal_pht
    import bpu_pkg::*;
#(
    parameter  int ENTRIES = 64,
    parameter  int CTR_W   = 2,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             clear,
    output logic             ready,
    input  logic             pred_valid,
    input  logic [IDX_W-1:0] pred_idx,
    output logic             pred_resp_valid,
    output logic             pred_taken,
    output logic [CTR_W-1:0] pred_ctr,
    input  logic             train_valid,
    input  logic [IDX_W-1:0] train_idx,
    input  logic             train_taken
);

    localparam logic [CTR_W-1:0] INIT_CTR = CTR_W'(init_ctr(CTR_W));
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    pht_state_e state;
    pht_state_e state_nxt;
    logic [IDX_W-1:0] sweep_ptr;
    logic [IDX_W-1:0] sweep_nxt;

    logic [CTR_W-1:0] table_q [ENTRIES];

    logic             running;
    logic             train_en;
    logic             lookup_en;
    logic [CTR_W-1:0] train_cur;
    logic [CTR_W-1:0] train_upd;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [CTR_W-1:0] wr_data;
    logic [CTR_W-1:0] rd_ctr;

    assign running   = (state == RUN);
    assign ready     = running;
    assign train_en  = running && train_valid && !clear;
    assign lookup_en = running && pred_valid;

    always_comb begin
        state_nxt = state;
        sweep_nxt = sweep_ptr;
        unique case (state)
            INIT: begin
                sweep_nxt = sweep_ptr + IDX_W'(1);
                if (clear)
                    sweep_nxt = '0;
                else if (sweep_ptr == LAST_IDX)
                    state_nxt = RUN;
            end
            RUN: begin
                if (clear) begin
                    state_nxt = INIT;
                    sweep_nxt = '0;
                end
            end
        endcase
    end

    assign train_cur = table_q[train_idx];

    sat_ctr_next #(
        .CTR_W   (CTR_W)
    ) u_sat (
        .ctr     (train_cur),
        .taken   (train_taken),
        .ctr_next(train_upd)
    );

    // Sweep owns the single write port until the table is usable.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = train_idx;
        wr_data = train_upd;
        if (!running) begin
            wr_en   = !areset;
            wr_idx  = sweep_ptr;
            wr_data = INIT_CTR;
        end else if (train_en) begin
            wr_en = !areset;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            table_q[wr_idx] <= wr_data;
    end

`ifdef BIMODAL_PHT_BYPASS_EN
    always_comb begin
        rd_ctr = table_q[pred_idx];
        if (train_en && (train_idx == pred_idx))
            rd_ctr = train_upd;
    end
`else
    assign rd_ctr = table_q[pred_idx];
`endif

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state           <= INIT;
            sweep_ptr       <= '0;
            pred_resp_valid <= 1'b0;
            pred_ctr        <= '0;
        end else begin
            state           <= state_nxt;
            sweep_ptr       <= sweep_nxt;
            pred_resp_valid <= lookup_en;
            if (lookup_en)
                pred_ctr <= rd_ctr;
        end
    end

    assign pred_taken = pred_ctr[CTR_W-1];

endmodule

// File: doc/bimodal_pht.md
BIMODAL_PHT -- requirements
Module: bimodal_pht

Interface
REQ-001 The block SHALL have parameter ENTRIES, default 64, number of counters; power of two, at least 2.
REQ-002 The block SHALL have parameter CTR_W, default 2, counter width in bits; at least 2.
REQ-003 The block SHALL have localparam IDX_W, equal to $clog2(ENTRIES), giving the index width.
REQ-004 The block SHALL have port clk, input, 1 bit: clock.
REQ-005 The block SHALL have port areset, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port clear, input, 1 bit: synchronous request to re-initialise the table.
REQ-007 The block SHALL have port ready, output, 1 bit: high when the table is usable, low during the init sweep.
REQ-008 The block SHALL have port pred_valid, input, 1 bit: prediction lookup request.
REQ-009 The block SHALL have port pred_idx, input, IDX_W bits: lookup index.
REQ-010 The block SHALL have port pred_resp_valid, output, 1 bit: lookup result valid, one cycle after the request.
REQ-011 The block SHALL have port pred_taken, output, 1 bit: MSB of the counter that was read.
REQ-012 The block SHALL have port pred_ctr, output, CTR_W bits: raw counter value that was read.
REQ-013 The block SHALL have port train_valid, input, 1 bit: training update request.
REQ-014 The block SHALL have port train_idx, input, IDX_W bits: index to update.
REQ-015 The block SHALL have port train_taken, input, 1 bit: resolved branch direction.

Function
REQ-016 The table SHALL hold ENTRIES counters of CTR_W bits each, with no reset on the storage array.
REQ-017 The initial counter value INIT SHALL be 2^(CTR_W-1)-1, weakly not-taken (2'b01 at CTR_W=2).
REQ-018 The FSM SHALL have two states, INIT and RUN; in INIT it writes INIT to entry sweep_ptr, increments sweep_ptr each cycle, and moves to RUN in the cycle after writing entry ENTRIES-1.
REQ-019 ready SHALL equal (state == RUN), be registered, and the sweep SHALL take exactly ENTRIES cycles.
REQ-020 In RUN, clear=1 SHALL move the FSM to INIT with sweep_ptr=0 on the next edge and drop ready; a train in that same cycle SHALL be discarded.
REQ-021 In INIT, clear=1 SHALL restart the sweep at entry 0.
REQ-022 In INIT, pred_valid and train_valid SHALL be ignored: pred_resp_valid=0 and no training write.
REQ-023 A lookup SHALL have latency 1: pred_resp_valid, pred_taken and pred_ctr are registered and reflect pred_idx from the previous cycle.
REQ-024 pred_taken and pred_ctr SHALL hold their last values while pred_resp_valid=0.
REQ-025 On train with train_taken=1, the counter SHALL become min(ctr+1, 2^CTR_W-1).
REQ-026 On train with train_taken=0, the counter SHALL become max(ctr-1, 0).
REQ-027 Counter arithmetic SHALL saturate and never wrap.
REQ-028 One train write SHALL occur per cycle; the written value SHALL be visible to a lookup issued the next cycle or later.
REQ-029 Simultaneous pred and train to different indices SHALL be independent.
REQ-030 Simultaneous pred and train to the same index SHALL follow REQ-034 / REQ-035.

Reset
REQ-031 On areset, the FSM SHALL enter INIT with sweep_ptr=0, and ready, pred_resp_valid, pred_taken and pred_ctr SHALL be 0.
REQ-032 An areset asserted mid-sweep or in RUN SHALL abort all activity and restart the sweep after deassertion.
REQ-033 The first sweep write SHALL occur on the first clk edge after areset deasserts.

Configuration
REQ-034 With BIMODAL_PHT_BYPASS_EN defined, a same-cycle, same-index pred and train SHALL return the post-update counter (write-first forwarding).
REQ-035 Without BIMODAL_PHT_BYPASS_EN, a same-cycle, same-index pred and train SHALL return the pre-update counter (read-first), with no forwarding logic present.

Structure
REQ-036 Package bpu_pkg SHALL hold the FSM state enum (INIT, RUN) and, for CTR_W=2, named constants SNT=0, WNT=1, WT=2, ST=3.
REQ-037 Sub-module sat_ctr_next SHALL be instantiated: combinational, parameter CTR_W, inputs ctr and taken, output the saturated next value; shared by the train and bypass paths.

Verification
REQ-038 Reset then idle, ENTRIES=64: ready=0 for 64 cycles then 1; a lookup of every index then returns pred_ctr=01, pred_taken=0.
REQ-039 Train idx 5 taken x4: lookup returns 10, 11, 11, 11 after the 1st, 2nd, 3rd and 4th trains; then not-taken x4 gives 10, 01, 00, 00.
REQ-040 CTR_W=3: 10 taken trains on idx 0 saturate at 111; pred_taken=1 from the 1st train onward (011 goes to 100).
REQ-041 Same-cycle pred and train on idx 9 at 01, taken: pred_ctr=10 with BIMODAL_PHT_BYPASS_EN, 01 without.
REQ-042 Train idx 3 to 11, pulse clear in RUN: ready drops for 64 cycles; idx 3 then reads 01; a train issued in the clear cycle has no effect.
REQ-043 areset asserted at sweep_ptr=30: outputs go to 0 immediately; after release a full 64-cycle sweep runs before ready=1.
